// File: rtl/cpu_pkg.sv
// Shared definitions for the bus CPU controller: opcodes, sequencer states and
// the bit positions of the control word driven to every bus agent.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_RST  = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4,
        ST_T5   = 3'd5,
        ST_T6   = 3'd6,
        ST_HALT = 3'd7
    } state_t;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_STA = 4'b0100;
    localparam logic [3:0] OP_LDI = 4'b0101;
    localparam logic [3:0] OP_JMP = 4'b0110;
    localparam logic [3:0] OP_JC  = 4'b0111;
    localparam logic [3:0] OP_JZ  = 4'b1000;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam int CW_W         = 15;
    localparam int CW_PC_OUT    = 0;
    localparam int CW_PC_INC    = 1;
    localparam int CW_PC_LOAD   = 2;
    localparam int CW_MAR_LOAD  = 3;
    localparam int CW_MEM_OUT   = 4;
    localparam int CW_MEM_IN    = 5;
    localparam int CW_IR_LOAD   = 6;
    localparam int CW_IR_OUT    = 7;
    localparam int CW_ACC_LOAD  = 8;
    localparam int CW_ACC_OUT   = 9;
    localparam int CW_BREG_LOAD = 10;
    localparam int CW_ALU_SUB   = 11;
    localparam int CW_ALU_OUT   = 12;
    localparam int CW_OUT_LOAD  = 13;
    localparam int CW_HALT      = 14;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational control-word decode: state, opcode and ALU flags to the control
// word, plus a flag marking the last state that does useful work for the opcode.
module ctrl_decode
    import cpu_pkg::*;
(
    input  state_t            state,
    input  logic [3:0]        opcode,
    input  logic              zero_flag,
    input  logic              carry_flag,
    output logic [CW_W-1:0]   cw,
    output logic              last_state
);

    always_comb begin
        cw         = '0;
        last_state = 1'b0;
        case (state)
            ST_T1: begin
                cw[CW_PC_OUT]   = 1'b1;
                cw[CW_MAR_LOAD] = 1'b1;
            end
            ST_T2: cw[CW_PC_INC] = 1'b1;
            ST_T3: begin
                cw[CW_MEM_OUT] = 1'b1;
                cw[CW_IR_LOAD] = 1'b1;
            end
            ST_T4: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        cw[CW_IR_OUT]   = 1'b1;
                        cw[CW_MAR_LOAD] = 1'b1;
                    end
                    OP_LDI: begin
                        cw[CW_IR_OUT]   = 1'b1;
                        cw[CW_ACC_LOAD] = 1'b1;
                        last_state      = 1'b1;
                    end
                    OP_JMP: begin
                        cw[CW_IR_OUT]  = 1'b1;
                        cw[CW_PC_LOAD] = 1'b1;
                        last_state     = 1'b1;
                    end
                    // Conditional jumps finish here whether or not they are taken.
                    OP_JC: begin
                        cw[CW_IR_OUT]  = carry_flag;
                        cw[CW_PC_LOAD] = carry_flag;
                        last_state     = 1'b1;
                    end
                    OP_JZ: begin
                        cw[CW_IR_OUT]  = zero_flag;
                        cw[CW_PC_LOAD] = zero_flag;
                        last_state     = 1'b1;
                    end
                    OP_OUT: begin
                        cw[CW_ACC_OUT]  = 1'b1;
                        cw[CW_OUT_LOAD] = 1'b1;
                        last_state      = 1'b1;
                    end
                    OP_HLT: last_state = 1'b0;
                    default: last_state = 1'b1;
                endcase
            end
            ST_T5: begin
                case (opcode)
                    OP_LDA: begin
                        cw[CW_MEM_OUT]  = 1'b1;
                        cw[CW_ACC_LOAD] = 1'b1;
                        last_state      = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        cw[CW_MEM_OUT]   = 1'b1;
                        cw[CW_BREG_LOAD] = 1'b1;
                    end
                    OP_STA: begin
                        cw[CW_ACC_OUT] = 1'b1;
                        cw[CW_MEM_IN]  = 1'b1;
                        last_state     = 1'b1;
                    end
                    default: last_state = 1'b1;
                endcase
            end
            ST_T6: begin
                last_state = 1'b1;
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    cw[CW_ALU_OUT]  = 1'b1;
                    cw[CW_ACC_LOAD] = 1'b1;
                    cw[CW_ALU_SUB]  = (opcode == OP_SUB);
                end
            end
            ST_HALT: cw[CW_HALT] = 1'b1;
            default: cw = '0;
        endcase
    end

endmodule

// File: rtl/ctrl_seq.sv
// Controller-sequencer for the 8-bit bus CPU: fixed three-state fetch followed by
// an opcode-decoded execute phase, with a sticky halt left only through clr_n.
module ctrl_seq
    import cpu_pkg::*;
#(
    parameter bit EARLY_END = 1'b0
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [3:0] opcode,
    input  logic       zero_flag,
    input  logic       carry_flag,
    output logic       pc_out,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       mar_load,
    output logic       mem_out,
    output logic       mem_in,
    output logic       ir_load,
    output logic       ir_out,
    output logic       acc_load,
    output logic       acc_out,
    output logic       breg_load,
    output logic       alu_sub,
    output logic       alu_out,
    output logic       out_load,
    output logic       halt,
    output logic [2:0] tstate
);

    state_t            state;
    state_t            state_nx;
    logic [CW_W-1:0]   cw;
    logic              last_state;

    ctrl_decode u_decode (
        .state      (state),
        .opcode     (opcode),
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag),
        .cw         (cw),
        .last_state (last_state)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_RST: state_nx = ST_T1;
            ST_T1:  state_nx = ST_T2;
            ST_T2:  state_nx = ST_T3;
            ST_T3:  state_nx = ST_T4;
            ST_T4, ST_T5, ST_T6: begin
                if (state == ST_T4 && opcode == OP_HLT)
                    state_nx = ST_HALT;
                else if (state == ST_T6 || (EARLY_END && last_state))
                    state_nx = ST_T1;
                else
                    state_nx = state_t'(state + 3'd1);
            end
            ST_HALT: state_nx = ST_HALT;
            default: state_nx = ST_RST;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)
            state <= ST_RST;
        else
            state <= state_nx;
    end

    assign pc_out    = cw[CW_PC_OUT];
    assign pc_inc    = cw[CW_PC_INC];
    assign pc_load   = cw[CW_PC_LOAD];
    assign mar_load  = cw[CW_MAR_LOAD];
    assign mem_out   = cw[CW_MEM_OUT];
    assign mem_in    = cw[CW_MEM_IN];
    assign ir_load   = cw[CW_IR_LOAD];
    assign ir_out    = cw[CW_IR_OUT];
    assign acc_load  = cw[CW_ACC_LOAD];
    assign acc_out   = cw[CW_ACC_OUT];
    assign breg_load = cw[CW_BREG_LOAD];
    assign alu_sub   = cw[CW_ALU_SUB];
    assign alu_out   = cw[CW_ALU_OUT];
    assign out_load  = cw[CW_OUT_LOAD];
    assign halt      = cw[CW_HALT];
    assign tstate    = state;

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq: one instance runs every state, a second instance
// uses the early-exit sequencing.
module tb_ctrl_seq;

    localparam logic [14:0] PC_OUT    = 15'h0001;
    localparam logic [14:0] PC_INC    = 15'h0002;
    localparam logic [14:0] PC_LOAD   = 15'h0004;
    localparam logic [14:0] MAR_LOAD  = 15'h0008;
    localparam logic [14:0] MEM_OUT   = 15'h0010;
    localparam logic [14:0] MEM_IN    = 15'h0020;
    localparam logic [14:0] IR_LOAD   = 15'h0040;
    localparam logic [14:0] IR_OUT    = 15'h0080;
    localparam logic [14:0] ACC_LOAD  = 15'h0100;
    localparam logic [14:0] ACC_OUT   = 15'h0200;
    localparam logic [14:0] BREG_LOAD = 15'h0400;
    localparam logic [14:0] ALU_SUB   = 15'h0800;
    localparam logic [14:0] ALU_OUT   = 15'h1000;
    localparam logic [14:0] OUT_LOAD  = 15'h2000;
    localparam logic [14:0] HALT      = 15'h4000;
    localparam logic [14:0] BUS_MASK  = PC_OUT | MEM_OUT | IR_OUT | ACC_OUT | ALU_OUT;

    logic        clk;
    logic        clr_a, clr_b;
    logic [3:0]  op_a, op_b;
    logic        zf_a, zf_b, cf_a, cf_b;
    wire  [14:0] cw_a, cw_b;
    wire  [2:0]  ts_a, ts_b;

    int vectors     = 0;
    int miscompares = 0;

    logic [14:0] e4 [16];
    logic [14:0] e5 [16];
    logic [14:0] e6 [16];

    ctrl_seq #(.EARLY_END(1'b0)) dut_a (
        .clk(clk), .clr_n(clr_a), .opcode(op_a), .zero_flag(zf_a), .carry_flag(cf_a),
        .pc_out(cw_a[0]), .pc_inc(cw_a[1]), .pc_load(cw_a[2]), .mar_load(cw_a[3]),
        .mem_out(cw_a[4]), .mem_in(cw_a[5]), .ir_load(cw_a[6]), .ir_out(cw_a[7]),
        .acc_load(cw_a[8]), .acc_out(cw_a[9]), .breg_load(cw_a[10]), .alu_sub(cw_a[11]),
        .alu_out(cw_a[12]), .out_load(cw_a[13]), .halt(cw_a[14]), .tstate(ts_a)
    );

    ctrl_seq #(.EARLY_END(1'b1)) dut_b (
        .clk(clk), .clr_n(clr_b), .opcode(op_b), .zero_flag(zf_b), .carry_flag(cf_b),
        .pc_out(cw_b[0]), .pc_inc(cw_b[1]), .pc_load(cw_b[2]), .mar_load(cw_b[3]),
        .mem_out(cw_b[4]), .mem_in(cw_b[5]), .ir_load(cw_b[6]), .ir_out(cw_b[7]),
        .acc_load(cw_b[8]), .acc_out(cw_b[9]), .breg_load(cw_b[10]), .alu_sub(cw_b[11]),
        .alu_out(cw_b[12]), .out_load(cw_b[13]), .halt(cw_b[14]), .tstate(ts_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] ts, input logic [14:0] cw,
                       input logic [2:0] ets, input logic [14:0] ecw);
        vectors++;
        assert ({ts, cw} === {ets, ecw}) else begin
            miscompares++;
            $error("FAIL %s: tstate=%0d cw=%h, expected tstate=%0d cw=%h", tag, ts, cw, ets, ecw);
        end
    endtask

    task automatic bus_chk(input string tag, input logic [14:0] cw);
        int n;
        n = $countones(cw & BUS_MASK);
        vectors++;
        assert (n <= 1) else begin
            miscompares++;
            $error("FAIL %s_bus: %0d bus drivers high (cw=%h), expected at most 1", tag, n, cw);
        end
    endtask

    task automatic step_a(input string tag, input logic [2:0] ets, input logic [14:0] ecw);
        tick();
        chk(tag, ts_a, cw_a, ets, ecw);
        bus_chk(tag, cw_a);
    endtask

    task automatic step_b(input string tag, input logic [2:0] ets, input logic [14:0] ecw);
        tick();
        chk(tag, ts_b, cw_b, ets, ecw);
        bus_chk(tag, cw_b);
    endtask

    task automatic fetch_a(input string tag);
        step_a({tag, "_T1"}, 3'd1, PC_OUT | MAR_LOAD);
        step_a({tag, "_T2"}, 3'd2, PC_INC);
        step_a({tag, "_T3"}, 3'd3, MEM_OUT | IR_LOAD);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            e4[i] = '0; e5[i] = '0; e6[i] = '0;
        end
        e4[0]  = IR_OUT | MAR_LOAD;  e5[0] = MEM_OUT | ACC_LOAD;
        e4[1]  = IR_OUT | MAR_LOAD;  e5[1] = MEM_OUT | BREG_LOAD; e6[1] = ALU_OUT | ACC_LOAD;
        e4[2]  = IR_OUT | MAR_LOAD;  e5[2] = MEM_OUT | BREG_LOAD; e6[2] = ALU_OUT | ACC_LOAD | ALU_SUB;
        e4[4]  = IR_OUT | MAR_LOAD;  e5[4] = ACC_OUT | MEM_IN;
        e4[5]  = IR_OUT | ACC_LOAD;
        e4[6]  = IR_OUT | PC_LOAD;
        e4[7]  = IR_OUT | PC_LOAD;
        e4[8]  = IR_OUT | PC_LOAD;
        e4[14] = ACC_OUT | OUT_LOAD;

        clr_a = 1'b0; clr_b = 1'b0;
        op_a = 4'd0; op_b = 4'd0;
        zf_a = 1'b0; zf_b = 1'b0; cf_a = 1'b0; cf_b = 1'b0;
        tick();
        tick();
        chk("rst_a", ts_a, cw_a, 3'd0, '0);
        chk("rst_b", ts_b, cw_b, 3'd0, '0);

        clr_a = 1'b1;
        #1;
        chk("release_a", ts_a, cw_a, 3'd0, '0);
        fetch_a("lda0");
        step_a("lda0_T4", 3'd4, IR_OUT | MAR_LOAD);
        step_a("lda0_T5", 3'd5, MEM_OUT | ACC_LOAD);

        // Asynchronous abort in the middle of T5.
        clr_a = 1'b0;
        #1;
        chk("abort_T5", ts_a, cw_a, 3'd0, '0);
        tick();
        chk("abort_hold", ts_a, cw_a, 3'd0, '0);
        clr_a = 1'b1;
        fetch_a("lda1");
        step_a("lda1_T4", 3'd4, IR_OUT | MAR_LOAD);
        step_a("lda1_T5", 3'd5, MEM_OUT | ACC_LOAD);
        step_a("lda1_T6", 3'd6, '0);

        zf_a = 1'b1; cf_a = 1'b1;
        for (int op = 0; op < 15; op++) begin
            op_a = 4'(op);
            fetch_a($sformatf("op%0d", op));
            step_a($sformatf("op%0d_T4", op), 3'd4, e4[op]);
            step_a($sformatf("op%0d_T5", op), 3'd5, e5[op]);
            step_a($sformatf("op%0d_T6", op), 3'd6, e6[op]);
        end

        op_a = 4'd8; zf_a = 1'b0;
        fetch_a("jz_nt");
        step_a("jz_nt_T4", 3'd4, '0);
        step_a("jz_nt_T5", 3'd5, '0);
        step_a("jz_nt_T6", 3'd6, '0);
        op_a = 4'd7; cf_a = 1'b0; zf_a = 1'b1;
        fetch_a("jc_nt");
        step_a("jc_nt_T4", 3'd4, '0);
        step_a("jc_nt_T5", 3'd5, '0);
        step_a("jc_nt_T6", 3'd6, '0);

        op_a = 4'd15;
        fetch_a("hlt");
        step_a("hlt_T4", 3'd4, '0);
        for (int i = 0; i < 20; i++)
            step_a($sformatf("halt%0d", i), 3'd7, HALT);
        clr_a = 1'b0;
        #1;
        chk("halt_clr", ts_a, cw_a, 3'd0, '0);
        tick();
        clr_a = 1'b1;
        op_a = 4'd0;
        step_a("after_halt_T1", 3'd1, PC_OUT | MAR_LOAD);

        clr_b = 1'b1; op_b = 4'd0;
        step_b("b_lda_T1", 3'd1, PC_OUT | MAR_LOAD);
        step_b("b_lda_T2", 3'd2, PC_INC);
        step_b("b_lda_T3", 3'd3, MEM_OUT | IR_LOAD);
        step_b("b_lda_T4", 3'd4, IR_OUT | MAR_LOAD);
        step_b("b_lda_T5", 3'd5, MEM_OUT | ACC_LOAD);
        step_b("b_jz_T1", 3'd1, PC_OUT | MAR_LOAD);
        op_b = 4'd8; zf_b = 1'b0;
        step_b("b_jz_T2", 3'd2, PC_INC);
        step_b("b_jz_T3", 3'd3, MEM_OUT | IR_LOAD);
        step_b("b_jz_nt_T4", 3'd4, '0);
        step_b("b_jzt_T1", 3'd1, PC_OUT | MAR_LOAD);
        zf_b = 1'b1;
        step_b("b_jzt_T2", 3'd2, PC_INC);
        step_b("b_jzt_T3", 3'd3, MEM_OUT | IR_LOAD);
        step_b("b_jzt_T4", 3'd4, IR_OUT | PC_LOAD);
        step_b("b_add_T1", 3'd1, PC_OUT | MAR_LOAD);
        op_b = 4'd1;
        step_b("b_add_T2", 3'd2, PC_INC);
        step_b("b_add_T3", 3'd3, MEM_OUT | IR_LOAD);
        step_b("b_add_T4", 3'd4, IR_OUT | MAR_LOAD);
        step_b("b_add_T5", 3'd5, MEM_OUT | BREG_LOAD);
        step_b("b_add_T6", 3'd6, ALU_OUT | ACC_LOAD);
        step_b("b_sta_T1", 3'd1, PC_OUT | MAR_LOAD);
        op_b = 4'd4;
        step_b("b_sta_T2", 3'd2, PC_INC);
        step_b("b_sta_T3", 3'd3, MEM_OUT | IR_LOAD);
        step_b("b_sta_T4", 3'd4, IR_OUT | MAR_LOAD);
        step_b("b_sta_T5", 3'd5, ACC_OUT | MEM_IN);
        step_b("b_end_T1", 3'd1, PC_OUT | MAR_LOAD);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
